uart_prog_loader: RTL and testbench

- UART boot/program loader that sits directly upstream of the CPU core's program interface.
- Deserializes the raw rx line (8N1) and packs bytes little-endian into 32-bit words.
- Drives the upg_* write bus: upg_adr bit 14 clear targets instruction memory; bit 14 set targets data memory.
- Asserts done when the image is complete or the line goes idle, which releases the CPU from programming mode.

---
 rtl/uart_prog_loader.sv | 138 +++++++++++++
 tb/tb_uart_prog_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART 8N1 boot loader: receives bytes, packs them little-endian into 32-bit words
// and writes them over the upg_* bus until the image is complete or the line idles.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned WORD_COUNT   = 32768,
  parameter int unsigned IDLE_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        frame_err_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TO_W  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic              rx_meta;
  logic              rxs;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [14:0]       word_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              sample_c;
  logic              byte_vld_c;
  logic              frame_bad_c;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign sample_c    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_vld_c  = (state == STOP) && sample_c && rxs && !upg_done_o;
  assign frame_bad_c = (state == STOP) && sample_c && !rxs && !upg_done_o;

  // Receiver FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
            clk_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (sample_c) begin
            clk_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (sample_c) begin
            clk_cnt <= '0;
            state   <= IDLE;
            if (frame_bad_c) frame_err_o <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word assembly, write strobe and completion/idle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= '0;
      word_buf   <= '0;
      word_cnt   <= '0;
      to_cnt     <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
    end else begin
      upg_wen_o <= 1'b0;
      if (byte_vld_c) begin
        to_cnt <= '0;
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= shift;
          2'd1: word_buf[15:8]  <= shift;
          2'd2: word_buf[23:16] <= shift;
          default: begin
            upg_wen_o <= 1'b1;
            upg_adr_o <= word_cnt;
            upg_dat_o <= {shift, word_buf};
            word_cnt  <= word_cnt + 15'd1;
            if (word_cnt == 15'(WORD_COUNT - 1)) upg_done_o <= 1'b1;
          end
        endcase
        byte_cnt <= byte_cnt + 2'd1;
      end else if (state == IDLE && !upg_done_o) begin
        // Only a line that has already delivered a word may time out
        if (to_cnt == TO_W'(IDLE_TIMEOUT - 1) && word_cnt != '0) begin
          upg_done_o <= 1'b1;
          byte_cnt   <= '0;
        end
        if (to_cnt != TO_W'(IDLE_TIMEOUT)) to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed cases plus randomized byte streams checked
// against a queue-based model of the loader.
module tb_uart_prog_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned WC  = 4;
  localparam int unsigned TO  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        frame_err_o;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .WORD_COUNT  (WC),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] adr;
    logic [31:0] dat;
    logic        done;
  } wr_t;

  wr_t got[$];
  wr_t exp[$];

  always @(negedge clk) begin
    if (upg_wen_o) got.push_back('{adr: upg_adr_o, dat: upg_dat_o, done: upg_done_o});
  end

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned t_start = 0;

  // Reference model state
  int unsigned m_bytes[$];
  int unsigned m_wc;
  bit          m_done;
  bit          m_ferr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    exp.delete();
    m_wc   = 0;
    m_done = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    wr_t w;
    if (m_done) return;
    if (!good) begin
      m_ferr = 1'b1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w.adr  = 15'(m_wc);
      w.dat  = m_bytes[0] + (m_bytes[1] << 8) + (m_bytes[2] << 16) + (m_bytes[3] << 24);
      w.done = (m_wc + 1 == WC);
      exp.push_back(w);
      m_bytes.delete();
      m_wc++;
      m_done = w.done;
    end
  endtask

  task automatic model_idle();
    if (!m_done && m_wc >= 1) begin
      m_done = 1'b1;
      m_bytes.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wen", 32'(upg_wen_o), 32'd0);
    check("rst_adr", 32'(upg_adr_o), 32'd0);
    check("rst_dat", upg_dat_o, 32'd0);
    check("rst_done", 32'(upg_done_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    rst = 1'b0;
    got.delete();
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    @(posedge clk);
    #1 rx = 1'b0;
    t_start = cyc;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = good;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    if (!good) repeat (CPB) @(posedge clk);
  endtask

  task automatic send_model(input logic [7:0] b, input bit good);
    model_byte(b, good);
    send_byte(b, good);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    check({tag, "_nwr"}, 32'(got.size()), 32'(exp.size()));
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_adr%0d", tag, i), 32'(got[i].adr), 32'(exp[i].adr));
      check($sformatf("%s_dat%0d", tag, i), got[i].dat, exp[i].dat);
      check($sformatf("%s_wdone%0d", tag, i), 32'(got[i].done), 32'(exp[i].done));
    end
    check({tag, "_done"}, 32'(upg_done_o), 32'(m_done));
    check({tag, "_ferr"}, 32'(frame_err_o), 32'(m_ferr));
    if (exp.size() > 0) begin
      check({tag, "_hold_adr"}, 32'(upg_adr_o), 32'(exp[exp.size()-1].adr));
      check({tag, "_hold_dat"}, upg_dat_o, exp[exp.size()-1].dat);
    end
  endtask

  logic [31:0] words_ref [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  int unsigned tgt;

  initial begin
    repeat (3) @(posedge clk);

    // Single word
    do_reset();
    send_model(8'h13, 1'b1); send_model(8'h00, 1'b1);
    send_model(8'h00, 1'b1); send_model(8'h00, 1'b1);
    settle(5);
    check("t1_nwr", 32'(got.size()), 32'd1);
    if (got.size() >= 1) begin
      check("t1_adr", 32'(got[0].adr), 32'h0);
      check("t1_dat", got[0].dat, 32'h00000013);
    end
    check("t1_done", 32'(upg_done_o), 32'd0);
    cmp_writes("t1");

    // Full image of four words, then an extra byte after done
    do_reset();
    for (int i = 0; i < 16; i++) send_model(8'(i), 1'b1);
    settle(5);
    check("t2_nwr", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check($sformatf("t2_adr%0d", i), 32'(got[i].adr), 32'(i));
      check($sformatf("t2_dat%0d", i), got[i].dat, words_ref[i]);
      check($sformatf("t2_wdone%0d", i), 32'(got[i].done), (i == 3) ? 32'd1 : 32'd0);
    end
    send_model(8'h10, 1'b1);
    settle(5);
    check("t2_extra_nwr", 32'(got.size()), 32'd4);
    check("t2_done", 32'(upg_done_o), 32'd1);

    // One-clock glitch on the line
    do_reset();
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    settle(20);
    check("t3_nwr", 32'(got.size()), 32'd0);
    check("t3_ferr", 32'(frame_err_o), 32'd0);
    check("t3_done", 32'(upg_done_o), 32'd0);

    // Bad stop bit discards that byte
    do_reset();
    send_model(8'hAA, 1'b0);
    send_model(8'h11, 1'b1); send_model(8'h22, 1'b1);
    send_model(8'h33, 1'b1); send_model(8'h44, 1'b1);
    settle(5);
    check("t4_ferr", 32'(frame_err_o), 32'd1);
    check("t4_nwr", 32'(got.size()), 32'd1);
    if (got.size() >= 1) begin
      check("t4_adr", 32'(got[0].adr), 32'h0);
      check("t4_dat", got[0].dat, 32'h44332211);
    end

    // Reset in the middle of a word
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("t6_wen", 32'(upg_wen_o), 32'd0);
    check("t6_adr", 32'(upg_adr_o), 32'd0);
    check("t6_dat", upg_dat_o, 32'd0);
    check("t6_done", 32'(upg_done_o), 32'd0);
    check("t6_ferr", 32'(frame_err_o), 32'd0);
    rst = 1'b0;
    got.delete();
    model_reset();
    send_model(8'hDE, 1'b1); send_model(8'hAD, 1'b1);
    send_model(8'hBE, 1'b1); send_model(8'hEF, 1'b1);
    settle(5);
    check("t6_nwr", 32'(got.size()), 32'd1);
    if (got.size() >= 1) check("t6_wdat", got[0].dat, 32'hEFBEADDE);
    cmp_writes("t6");

    // Idle timeout after one and a half words: exact timing and dropped partial
    do_reset();
    for (int i = 0; i < 6; i++) send_model(8'(i), 1'b1);
    // Stop bit of the last byte is sampled 3 + CPB/2 + 9*CPB clocks after its start edge
    tgt = t_start + 3 + CPB / 2 + 9 * CPB + TO;
    while (cyc < tgt - 1) @(negedge clk);
    check("t5_done_early", 32'(upg_done_o), 32'd0);
    @(negedge clk);
    check("t5_done_edge", 32'(upg_done_o), 32'd1);
    model_idle();
    send_model(8'h77, 1'b1);
    settle(10);
    cmp_writes("t5");

    // No timeout before the first word completes
    do_reset();
    send_model(8'hA1, 1'b1); send_model(8'hB2, 1'b1); send_model(8'hC3, 1'b1);
    settle(3 * TO);
    check("t7_done_nowrd", 32'(upg_done_o), 32'd0);
    send_model(8'hD4, 1'b1);
    settle(5);
    cmp_writes("t7a");
    settle(TO + 10);
    model_idle();
    cmp_writes("t7b");

    // Randomized streams
    for (int r = 0; r < 8; r++) begin
      int nb;
      do_reset();
      nb = $urandom_range(1, 20);
      for (int k = 0; k < nb; k++) begin
        logic [7:0] b;
        bit         good;
        b    = 8'($urandom);
        good = m_done || ($urandom_range(0, 9) != 0);
        repeat ($urandom_range(0, 6)) @(posedge clk);
        send_model(b, good);
      end
      settle(5);
      cmp_writes($sformatf("rnd%0d_a", r));
      settle(TO + 10);
      model_idle();
      cmp_writes($sformatf("rnd%0d_b", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
